// File: rtl/lc3_pkg.sv
// Shared LC3 definitions: opcodes, control-field codes and the execute control word layout.
// Used by decode, execute, writeback and the verification predictor.
package lc3_pkg;

    typedef enum logic [3:0] {
        OP_BR   = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_LD   = 4'b0010,
        OP_ST   = 4'b0011,
        OP_JSR  = 4'b0100,
        OP_AND  = 4'b0101,
        OP_LDR  = 4'b0110,
        OP_STR  = 4'b0111,
        OP_RTI  = 4'b1000,
        OP_NOT  = 4'b1001,
        OP_LDI  = 4'b1010,
        OP_STI  = 4'b1011,
        OP_JMP  = 4'b1100,
        OP_RES  = 4'b1101,
        OP_LEA  = 4'b1110,
        OP_TRAP = 4'b1111
    } op_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_AND = 2'b01;
    localparam logic [1:0] ALU_NOT = 2'b10;

    localparam logic [1:0] PCS1_NONE = 2'b00;
    localparam logic [1:0] PCS1_OFF9 = 2'b01;
    localparam logic [1:0] PCS1_OFF6 = 2'b10;
    localparam logic [1:0] PCS1_ZERO = 2'b11;

    localparam logic [1:0] W_ALU = 2'b00;
    localparam logic [1:0] W_PC  = 2'b01;
    localparam logic [1:0] W_MEM = 2'b10;

    // Bit order matches the e_control bus: {alu, pcselect1, pcselect2, op2select}.
    typedef struct packed {
        logic [1:0] alu_control;
        logic [1:0] pcselect1;
        logic       pcselect2;
        logic       op2select;
    } e_ctrl_t;

endpackage

// File: rtl/lc3_decode_if.sv
// Decode-stage bus: fetch-side inputs plus the registered decode outputs.
// The decoder drives the outputs through the master modport.
interface lc3_decode_if;

    logic        enable_decode;
    logic [15:0] Instr_dout;
    logic [15:0] npc_in;
    logic [15:0] IR;
    logic [15:0] npc_out;
    logic [5:0]  e_control;
    logic [1:0]  w_control;
    logic        mem_control;

    modport master (
        input  enable_decode, Instr_dout, npc_in,
        output IR, npc_out, e_control, w_control, mem_control
    );

    modport slave (
        output enable_decode, Instr_dout, npc_in,
        input  IR, npc_out, e_control, w_control, mem_control
    );

endinterface

// File: rtl/lc3_decode_ctrl.sv
// Combinational LC3 instruction decoder: instruction word to execute/writeback/memory controls.
// Unsupported opcodes produce all-zero controls.
module lc3_decode_ctrl
    import lc3_pkg::*;
(
    input  logic [15:0] instr,
    output e_ctrl_t     e_control,
    output logic [1:0]  w_control,
    output logic        mem_control
);

    op_t opcode;
    assign opcode = op_t'(instr[15:12]);

    always_comb begin
        e_control   = '0;
        w_control   = W_ALU;
        mem_control = 1'b0;
        unique case (opcode)
            OP_ADD: begin
                e_control.alu_control = ALU_ADD;
                e_control.op2select   = ~instr[5];
            end
            OP_AND: begin
                e_control.alu_control = ALU_AND;
                e_control.op2select   = ~instr[5];
            end
            OP_NOT: e_control.alu_control = ALU_NOT;
            OP_BR, OP_LD, OP_LDI, OP_LEA, OP_ST, OP_STI: begin
                e_control.pcselect1 = PCS1_OFF9;
                e_control.pcselect2 = 1'b1;
            end
            OP_LDR, OP_STR: e_control.pcselect1 = PCS1_OFF6;
            OP_JMP:         e_control.pcselect1 = PCS1_ZERO;
            default: ;
        endcase

        // Writeback source and indirect flag depend only on the opcode.
        case (opcode)
            OP_LD, OP_LDR, OP_LDI: w_control = W_MEM;
            OP_LEA:                w_control = W_PC;
            default:               w_control = W_ALU;
        endcase
        mem_control = (opcode == OP_LDI) || (opcode == OP_STI);
    end

endmodule

// File: rtl/lc3_decode.sv
// LC3 decode stage: registers the fetched instruction and npc and the decoded control words.
// Loads on enable_decode, holds otherwise; synchronous reset clears everything.
module lc3_decode
    import lc3_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    lc3_decode_if.master bus
);

    e_ctrl_t     dec_e;
    logic [1:0]  dec_w;
    logic        dec_mem;

    logic [15:0] ir_d,  ir_q;
    logic [15:0] npc_d, npc_q;
    e_ctrl_t     e_d,   e_q;
    logic [1:0]  w_d,   w_q;
    logic        mem_d, mem_q;

    lc3_decode_ctrl u_ctrl (
        .instr       (bus.Instr_dout),
        .e_control   (dec_e),
        .w_control   (dec_w),
        .mem_control (dec_mem)
    );

    always_comb begin
        ir_d  = ir_q;
        npc_d = npc_q;
        e_d   = e_q;
        w_d   = w_q;
        mem_d = mem_q;
        if (bus.enable_decode) begin
            ir_d  = bus.Instr_dout;
            npc_d = bus.npc_in;
            e_d   = dec_e;
            w_d   = dec_w;
            mem_d = dec_mem;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ir_q  <= '0;
            npc_q <= '0;
            e_q   <= '0;
            w_q   <= '0;
            mem_q <= 1'b0;
        end else begin
            ir_q  <= ir_d;
            npc_q <= npc_d;
            e_q   <= e_d;
            w_q   <= w_d;
            mem_q <= mem_d;
        end
    end

    assign bus.IR          = ir_q;
    assign bus.npc_out     = npc_q;
    assign bus.e_control   = e_q;
    assign bus.w_control   = w_q;
    assign bus.mem_control = mem_q;

endmodule

// File: tb/tb_lc3_decode.sv
// Directed self-checking bench for lc3_decode with hand-computed expected outputs.
// Observed/expected are packed as {IR, npc_out, e_control, w_control, mem_control}.
module tb_lc3_decode;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    lc3_decode_if bus ();

    lc3_decode dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [40:0] obs;
    logic [40:0] exp_v;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.enable_decode = 1'b1;
        bus.Instr_dout = 16'h1283;
        bus.npc_in = 16'h3001;
        for (int i = 0; i < 2; i++) begin
            tick();
            obs = {bus.IR, bus.npc_out, bus.e_control, bus.w_control, bus.mem_control};
            exp_v = '0;
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL reset_cycle%0d: got %h expected %h", i, obs, exp_v);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_decode_ops();
        logic [15:0] instr_tab [8];
        logic [15:0] npc_tab   [8];
        logic [5:0]  e_tab     [8];
        logic [1:0]  w_tab     [8];
        logic        m_tab     [8];
        instr_tab = '{16'h1283, 16'h12A5, 16'h5283, 16'h927F,
                      16'h6283, 16'hA200, 16'hE205, 16'hC1C0};
        npc_tab   = '{16'h3001, 16'h3002, 16'h3003, 16'h3004,
                      16'h3005, 16'h3006, 16'h3007, 16'h3008};
        e_tab     = '{6'b000001, 6'b000000, 6'b010001, 6'b100000,
                      6'b001000, 6'b000110, 6'b000110, 6'b001100};
        w_tab     = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd1, 2'd0};
        m_tab     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        bus.enable_decode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.Instr_dout = instr_tab[i];
            bus.npc_in = npc_tab[i];
            tick();
            obs = {bus.IR, bus.npc_out, bus.e_control, bus.w_control, bus.mem_control};
            exp_v = {instr_tab[i], npc_tab[i], e_tab[i], w_tab[i], m_tab[i]};
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL decode_%h: got %h expected %h", instr_tab[i], obs, exp_v);
            end
        end
    endtask

    task automatic test_hold();
        bus.enable_decode = 1'b1;
        bus.Instr_dout = 16'h0E05;
        bus.npc_in = 16'h3100;
        tick();
        bus.enable_decode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.Instr_dout = 16'h5283;
            bus.npc_in = 16'h4000 + 16'(i);
            tick();
            obs = {bus.IR, bus.npc_out, bus.e_control, bus.w_control, bus.mem_control};
            exp_v = {16'h0E05, 16'h3100, 6'b000110, 2'd0, 1'b0};
            tests++;
            if (obs !== exp_v) begin
                fails++;
                $display("FAIL hold_cycle%0d: got %h expected %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_reset_priority();
        bus.enable_decode = 1'b1;
        bus.Instr_dout = 16'hA200;
        bus.npc_in = 16'h3200;
        tick();
        rst = 1'b1;
        tick();
        obs = {bus.IR, bus.npc_out, bus.e_control, bus.w_control, bus.mem_control};
        exp_v = '0;
        tests++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL reset_priority: got %h expected %h", obs, exp_v);
        end
        rst = 1'b0;
        bus.enable_decode = 1'b0;
        tick();
        obs = {bus.IR, bus.npc_out, bus.e_control, bus.w_control, bus.mem_control};
        tests++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL release_no_enable: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_unsupported();
        bus.enable_decode = 1'b1;
        bus.Instr_dout = 16'h1283;
        bus.npc_in = 16'h300F;
        tick();
        bus.Instr_dout = 16'hF025;
        bus.npc_in = 16'h3010;
        tick();
        obs = {bus.IR, bus.npc_out, bus.e_control, bus.w_control, bus.mem_control};
        exp_v = {16'hF025, 16'h3010, 6'b000000, 2'd0, 1'b0};
        tests++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL unsupported_trap: got %h expected %h", obs, exp_v);
        end
        bus.Instr_dout = 16'hB1FF;
        bus.npc_in = 16'h3011;
        tick();
        obs = {bus.IR, bus.npc_out, bus.e_control, bus.w_control, bus.mem_control};
        exp_v = {16'hB1FF, 16'h3011, 6'b000110, 2'd0, 1'b1};
        tests++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL sti_decode: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_back_to_back();
        bus.enable_decode = 1'b1;
        bus.Instr_dout = 16'h1283;
        bus.npc_in = 16'h3020;
        tick();
        obs = {bus.IR, bus.npc_out, bus.e_control, bus.w_control, bus.mem_control};
        exp_v = {16'h1283, 16'h3020, 6'b000001, 2'd0, 1'b0};
        tests++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL b2b_add: got %h expected %h", obs, exp_v);
        end
        // Changing inputs mid-cycle must not reach the outputs before the next edge.
        bus.Instr_dout = 16'h2403;
        bus.npc_in = 16'h3021;
        #2;
        obs = {bus.IR, bus.npc_out, bus.e_control, bus.w_control, bus.mem_control};
        tests++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL no_comb_path: got %h expected %h", obs, exp_v);
        end
        tick();
        obs = {bus.IR, bus.npc_out, bus.e_control, bus.w_control, bus.mem_control};
        exp_v = {16'h2403, 16'h3021, 6'b000110, 2'd2, 1'b0};
        tests++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL b2b_ld: got %h expected %h", obs, exp_v);
        end
        bus.Instr_dout = 16'h7283;
        bus.npc_in = 16'h3022;
        tick();
        obs = {bus.IR, bus.npc_out, bus.e_control, bus.w_control, bus.mem_control};
        exp_v = {16'h7283, 16'h3022, 6'b001000, 2'd0, 1'b0};
        tests++;
        if (obs !== exp_v) begin
            fails++;
            $display("FAIL b2b_str: got %h expected %h", obs, exp_v);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.enable_decode = 1'b0;
        bus.Instr_dout = '0;
        bus.npc_in = '0;
        test_reset();
        test_decode_ops();
        test_hold();
        test_reset_priority();
        test_unsupported();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
